// File: rtl/gf_sw_pkg.sv
// Shared types and constants for the scatter->gather switch routing elements.
package gf_sw_pkg;

  localparam int DATA_W = 32;
  localparam int NULL_W = 22;

  typedef logic [DATA_W-1:0] sw_word_t;

  localparam sw_word_t NULL_MASK = {{(DATA_W-NULL_W){1'b0}}, {NULL_W{1'b1}}};

  // A null message carries an all-ones vertex payload field.
  function automatic logic is_null(input sw_word_t w);
    return ((w & NULL_MASK) == NULL_MASK);
  endfunction

endpackage

// File: rtl/gf_sw_fifo.sv
// Synchronous first-word-fall-through queue with occupancy count and a
// registered almost-full flag that reflects the count after each edge.
module gf_sw_fifo
  import gf_sw_pkg::*;
#(
  parameter int DEPTH   = 32,
  parameter int FULL_TH = 22
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  sw_word_t                 din,
  input  logic                     pop,
  output sw_word_t                 dout,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     empty,
  output logic                     full,
  output logic                     prog_full
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  sw_word_t          mem_r [DEPTH];
  logic [AW-1:0]     wr_ptr_r;
  logic [AW-1:0]     rd_ptr_r;
  logic [CW-1:0]     count_r;
  logic              prog_full_r;
  logic              wr_en_s;
  logic              rd_en_s;
  logic [CW-1:0]     count_next_s;

  assign empty     = (count_r == {CW{1'b0}});
  assign full      = (count_r == CW'(DEPTH));
  assign count     = count_r;
  assign prog_full = prog_full_r;
  assign dout      = mem_r[rd_ptr_r];

  // A full queue still accepts a write when the same edge frees a slot.
  always_comb begin
    wr_en_s      = push & (~full | pop);
    rd_en_s      = pop & ~empty;
    count_next_s = count_r;
    case ({wr_en_s, rd_en_s})
      2'b10:   count_next_s = count_r + CW'(1);
      2'b01:   count_next_s = count_r - CW'(1);
      default: count_next_s = count_r;
    endcase
  end

  // Storage array write port.
  always_ff @(posedge clk) begin
    if (wr_en_s && !rst) begin
      mem_r[wr_ptr_r] <= din;
    end
  end

  // Pointers, occupancy and almost-full flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_r    <= {AW{1'b0}};
      rd_ptr_r    <= {AW{1'b0}};
      count_r     <= {CW{1'b0}};
      prog_full_r <= 1'b0;
    end else begin
      if (wr_en_s) begin
        wr_ptr_r <= wr_ptr_r + AW'(1);
      end
      if (rd_en_s) begin
        rd_ptr_r <= rd_ptr_r + AW'(1);
      end
      count_r     <= count_next_s;
      prog_full_r <= (count_next_s >= CW'(FULL_TH));
    end
  end

endmodule

// File: rtl/gf_sw_router_2x2.sv
// 2x2 buffered routing element: per-input/per-output queues, round-robin output
// arbitration with backpressure. Optional macro GF_SW_DROP_NULL_EN discards nulls.
module gf_sw_router_2x2
  import gf_sw_pkg::*;
#(
  parameter int ROUTE_BIT  = 22,
  parameter int FIFO_DEPTH = 32,
  parameter int FULL_TH    = 22
) (
  input  logic     ap_clk,
  input  logic     ap_rst,
  input  logic     sw_ivld_0,
  input  sw_word_t sw_idata_0,
  input  logic     sw_ivld_1,
  input  sw_word_t sw_idata_1,
  output logic     sw_ofw_0,
  output logic     sw_ofw_1,
  output logic     sw_ovld_0,
  output sw_word_t sw_odata_0,
  output logic     sw_ovld_1,
  output sw_word_t sw_odata_1,
  input  logic     sw_bp_0,
  input  logic     sw_bp_1,
  output logic     err_ovf
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  logic [1:0]      ivld_s;
  sw_word_t        idata_s [2];
  logic [1:0]      keep_s;
  logic [1:0]      bp_s;
  logic [1:0][1:0] req_s;
  logic [1:0][1:0] push_s;
  logic [1:0][1:0] pop_s;
  logic [1:0][1:0] empty_s;
  logic [1:0][1:0] full_s;
  logic [1:0][1:0] pf_s;
  logic [1:0][1:0] ovf_s;
  sw_word_t        dout_s  [2][2];
  logic [CW-1:0]   count_s [2][2];
  logic [1:0]      gsel_s;
  logic [1:0]      pop_any_s;
  sw_word_t        sel_data_s [2];

  logic [1:0]      rr_r;
  logic [1:0]      ovld_r;
  sw_word_t        odata_r [2];
  logic            err_r;

  // Input routing: steer each message on its destination bit.
  always_comb begin
    ivld_s     = {sw_ivld_1, sw_ivld_0};
    idata_s[0] = sw_idata_0;
    idata_s[1] = sw_idata_1;
    bp_s       = {sw_bp_1, sw_bp_0};
    for (int i = 0; i < 2; i++) begin
`ifdef GF_SW_DROP_NULL_EN
      keep_s[i] = ~is_null(idata_s[i]);
`else
      keep_s[i] = 1'b1;
`endif
      req_s[i][0] = ivld_s[i] & keep_s[i] & ~idata_s[i][ROUTE_BIT];
      req_s[i][1] = ivld_s[i] & keep_s[i] &  idata_s[i][ROUTE_BIT];
    end
  end

  for (genvar gi = 0; gi < 2; gi++) begin : g_in
    for (genvar gj = 0; gj < 2; gj++) begin : g_out
      gf_sw_fifo #(
        .DEPTH   (FIFO_DEPTH),
        .FULL_TH (FULL_TH)
      ) u_fifo (
        .clk       (ap_clk),
        .rst       (ap_rst),
        .push      (push_s[gi][gj]),
        .din       (idata_s[gi]),
        .pop       (pop_s[gi][gj]),
        .dout      (dout_s[gi][gj]),
        .count     (count_s[gi][gj]),
        .empty     (empty_s[gi][gj]),
        .full      (full_s[gi][gj]),
        .prog_full (pf_s[gi][gj])
      );
    end
  end

  // Round-robin arbitration per output; rr_r holds the lane favoured next.
  always_comb begin
    gsel_s        = 2'b00;
    pop_any_s     = 2'b00;
    pop_s         = '0;
    sel_data_s[0] = dout_s[0][0];
    sel_data_s[1] = dout_s[0][1];
    for (int j = 0; j < 2; j++) begin
      if (!empty_s[0][j] && !empty_s[1][j]) begin
        gsel_s[j] = rr_r[j];
      end else if (!empty_s[1][j]) begin
        gsel_s[j] = 1'b1;
      end else begin
        gsel_s[j] = 1'b0;
      end
      pop_any_s[j]   = (~empty_s[0][j] | ~empty_s[1][j]) & ~bp_s[j];
      pop_s[0][j]    = pop_any_s[j] & ~gsel_s[j];
      pop_s[1][j]    = pop_any_s[j] &  gsel_s[j];
      sel_data_s[j]  = gsel_s[j] ? dout_s[1][j] : dout_s[0][j];
    end
  end

  // Writes land unless the queue is saturated and not draining this edge.
  always_comb begin
    push_s = '0;
    ovf_s  = '0;
    for (int i = 0; i < 2; i++) begin
      for (int j = 0; j < 2; j++) begin
        push_s[i][j] = req_s[i][j] & (~full_s[i][j] | pop_s[i][j]);
        ovf_s[i][j]  = req_s[i][j] & (count_s[i][j] == CW'(FIFO_DEPTH)) & ~pop_s[i][j];
      end
    end
  end

  // Output registers, arbiter pointers and sticky overflow flag.
  always_ff @(posedge ap_clk) begin
    if (ap_rst) begin
      rr_r       <= 2'b00;
      ovld_r     <= 2'b00;
      odata_r[0] <= '0;
      odata_r[1] <= '0;
      err_r      <= 1'b0;
    end else begin
      ovld_r <= pop_any_s;
      for (int j = 0; j < 2; j++) begin
        if (pop_any_s[j]) begin
          odata_r[j] <= sel_data_s[j];
          rr_r[j]    <= ~gsel_s[j];
        end
      end
      if (|ovf_s) begin
        err_r <= 1'b1;
      end
    end
  end

  assign sw_ovld_0  = ovld_r[0];
  assign sw_ovld_1  = ovld_r[1];
  assign sw_odata_0 = odata_r[0];
  assign sw_odata_1 = odata_r[1];
  assign sw_ofw_0   = pf_s[0][0] | pf_s[0][1];
  assign sw_ofw_1   = pf_s[1][0] | pf_s[1][1];
  assign err_ovf    = err_r;

endmodule

// File: tb/tb_gf_sw_router_2x2.sv
// Scoreboard bench for gf_sw_router_2x2: expected words queued per output when
// driven, popped and compared by an output monitor.
module tb_gf_sw_router_2x2;
  import gf_sw_pkg::*;

  logic     ap_clk = 1'b0;
  logic     ap_rst = 1'b1;
  logic     sw_ivld_0 = 1'b0, sw_ivld_1 = 1'b0;
  sw_word_t sw_idata_0 = '0, sw_idata_1 = '0;
  logic     sw_ofw_0, sw_ofw_1;
  logic     sw_ovld_0, sw_ovld_1;
  sw_word_t sw_odata_0, sw_odata_1;
  logic     sw_bp_0 = 1'b0, sw_bp_1 = 1'b0;
  logic     err_ovf;

  int       tests_run = 0;
  int       tests_failed = 0;
  sw_word_t exp_q0[$];
  sw_word_t exp_q1[$];
  sw_word_t hold0 = '0, hold1 = '0;
  sw_word_t e0, e1;
  logic     mon_en = 1'b0;

  gf_sw_router_2x2 dut (
    .ap_clk     (ap_clk),
    .ap_rst     (ap_rst),
    .sw_ivld_0  (sw_ivld_0),
    .sw_idata_0 (sw_idata_0),
    .sw_ivld_1  (sw_ivld_1),
    .sw_idata_1 (sw_idata_1),
    .sw_ofw_0   (sw_ofw_0),
    .sw_ofw_1   (sw_ofw_1),
    .sw_ovld_0  (sw_ovld_0),
    .sw_odata_0 (sw_odata_0),
    .sw_ovld_1  (sw_ovld_1),
    .sw_odata_1 (sw_odata_1),
    .sw_bp_0    (sw_bp_0),
    .sw_bp_1    (sw_bp_1),
    .err_ovf    (err_ovf)
  );

  always #5 ap_clk = ~ap_clk;

  // Output monitor: every pulse must match the scoreboard head; idle data must hold.
  always @(negedge ap_clk) begin
    if (mon_en) begin
      tests_run++;
      if (sw_ovld_0) begin
        if (exp_q0.size() == 0) begin
          tests_failed++;
          $display("FAIL out0_unexpected got=%h required no message", sw_odata_0);
        end else begin
          e0 = exp_q0.pop_front();
          if (sw_odata_0 !== e0) begin
            tests_failed++;
            $display("FAIL out0_data got=%h required %h", sw_odata_0, e0);
          end
        end
        hold0 = sw_odata_0;
      end else if (sw_odata_0 !== hold0) begin
        tests_failed++;
        $display("FAIL out0_hold got=%h required %h", sw_odata_0, hold0);
      end
      tests_run++;
      if (sw_ovld_1) begin
        if (exp_q1.size() == 0) begin
          tests_failed++;
          $display("FAIL out1_unexpected got=%h required no message", sw_odata_1);
        end else begin
          e1 = exp_q1.pop_front();
          if (sw_odata_1 !== e1) begin
            tests_failed++;
            $display("FAIL out1_data got=%h required %h", sw_odata_1, e1);
          end
        end
        hold1 = sw_odata_1;
      end else if (sw_odata_1 !== hold1) begin
        tests_failed++;
        $display("FAIL out1_hold got=%h required %h", sw_odata_1, hold1);
      end
    end
  end

  task automatic tick();
    @(posedge ap_clk);
    #1;
  endtask

  task automatic wait_drain(input string name);
    int n;
    n = 0;
    while ((exp_q0.size() != 0 || exp_q1.size() != 0) && n < 200) begin
      @(posedge ap_clk);
      n++;
    end
    repeat (4) @(posedge ap_clk);
    #1;
    tests_run++;
    if (exp_q0.size() != 0 || exp_q1.size() != 0) begin
      tests_failed++;
      $display("FAIL %s_drain left q0=%0d q1=%0d required 0", name, exp_q0.size(), exp_q1.size());
    end
  endtask

  task automatic test_reset();
    ap_rst = 1'b1;
    repeat (2) tick();
    @(negedge ap_clk);
    tests_run++;
    if ({sw_ovld_0, sw_ovld_1, sw_ofw_0, sw_ofw_1, err_ovf} !== 5'b00000) begin
      tests_failed++;
      $display("FAIL reset_flags got=%b required 00000", {sw_ovld_0, sw_ovld_1, sw_ofw_0, sw_ofw_1, err_ovf});
    end
    tests_run++;
    if (sw_odata_0 !== 32'h0 || sw_odata_1 !== 32'h0) begin
      tests_failed++;
      $display("FAIL reset_data got=%h/%h required 0/0", sw_odata_0, sw_odata_1);
    end
    hold0  = '0;
    hold1  = '0;
    mon_en = 1'b1;
    ap_rst = 1'b0;
    tick();
  endtask

  task automatic test_single();
    sw_ivld_0  = 1'b1;
    sw_idata_0 = 32'h0000_0005;
    exp_q0.push_back(32'h0000_0005);
    tick();
    sw_ivld_0 = 1'b0;
    @(negedge ap_clk);
    tests_run++;
    if (sw_ovld_0 !== 1'b0) begin
      tests_failed++;
      $display("FAIL single_t1 ovld0=%b required 0", sw_ovld_0);
    end
    tick();
    @(negedge ap_clk);
    tests_run++;
    if (sw_ovld_0 !== 1'b1 || sw_odata_0 !== 32'h5 || sw_ovld_1 !== 1'b0) begin
      tests_failed++;
      $display("FAIL single_t2 ovld0=%b odata0=%h ovld1=%b required 1 00000005 0", sw_ovld_0, sw_odata_0, sw_ovld_1);
    end
    wait_drain("single");
  endtask

  task automatic test_contention();
    sw_ivld_0  = 1'b1;
    sw_idata_0 = 32'h0040_0001;
    sw_ivld_1  = 1'b1;
    sw_idata_1 = 32'h0040_0002;
    exp_q1.push_back(32'h0040_0001);
    exp_q1.push_back(32'h0040_0002);
    tick();
    sw_ivld_0 = 1'b0;
    sw_ivld_1 = 1'b0;
    tick();
    @(negedge ap_clk);
    tests_run++;
    if (sw_ovld_1 !== 1'b1 || sw_odata_1 !== 32'h0040_0001) begin
      tests_failed++;
      $display("FAIL contention_first ovld1=%b odata1=%h required 1 00400001", sw_ovld_1, sw_odata_1);
    end
    tick();
    @(negedge ap_clk);
    tests_run++;
    if (sw_ovld_1 !== 1'b1 || sw_odata_1 !== 32'h0040_0002) begin
      tests_failed++;
      $display("FAIL contention_second ovld1=%b odata1=%h required 1 00400002", sw_ovld_1, sw_odata_1);
    end
    wait_drain("contention");
  endtask

  task automatic test_rr_alternate();
    sw_bp_1 = 1'b1;
    for (int k = 0; k < 3; k++) begin
      sw_ivld_0  = 1'b1;
      sw_idata_0 = 32'h0040_0A00 + 32'(k);
      sw_ivld_1  = 1'b1;
      sw_idata_1 = 32'h0040_0B00 + 32'(k);
      exp_q1.push_back(32'h0040_0A00 + 32'(k));
      exp_q1.push_back(32'h0040_0B00 + 32'(k));
      tick();
    end
    sw_ivld_0 = 1'b0;
    sw_ivld_1 = 1'b0;
    tick();
    @(negedge ap_clk);
    tests_run++;
    if (sw_ovld_1 !== 1'b0) begin
      tests_failed++;
      $display("FAIL rr_bp_hold ovld1=%b required 0", sw_ovld_1);
    end
    sw_bp_1 = 1'b0;
    wait_drain("rr");
  endtask

  task automatic test_back_to_back();
    for (int k = 0; k < 10; k++) begin
      if (k < 8) begin
        sw_ivld_0  = 1'b1;
        sw_idata_0 = 32'h0000_1000 + 32'(k);
        sw_ivld_1  = 1'b1;
        sw_idata_1 = 32'h0040_2000 + 32'(k);
        exp_q0.push_back(32'h0000_1000 + 32'(k));
        exp_q1.push_back(32'h0040_2000 + 32'(k));
      end else begin
        sw_ivld_0 = 1'b0;
        sw_ivld_1 = 1'b0;
      end
      tick();
      @(negedge ap_clk);
      if (k >= 1 && k <= 8) begin
        tests_run++;
        if (sw_ovld_0 !== 1'b1 || sw_ovld_1 !== 1'b1) begin
          tests_failed++;
          $display("FAIL b2b_stream k=%0d ovld0=%b ovld1=%b required 1 1", k, sw_ovld_0, sw_ovld_1);
        end
      end
    end
    wait_drain("b2b");
  endtask

  task automatic test_backpressure();
    sw_bp_0 = 1'b1;
    for (int k = 0; k < 22; k++) begin
      sw_ivld_0  = 1'b1;
      sw_idata_0 = 32'h0000_0100 + 32'(k);
      exp_q0.push_back(32'h0000_0100 + 32'(k));
      tick();
      @(negedge ap_clk);
      tests_run++;
      if (sw_ovld_0 !== 1'b0) begin
        tests_failed++;
        $display("FAIL bp_no_pop k=%0d ovld0=%b required 0", k, sw_ovld_0);
      end
      if (k >= 20) begin
        tests_run++;
        if (sw_ofw_0 !== (k == 21) || sw_ofw_1 !== 1'b0) begin
          tests_failed++;
          $display("FAIL bp_ofw k=%0d ofw0=%b ofw1=%b required %b 0", k, sw_ofw_0, sw_ofw_1, (k == 21));
        end
      end
    end
    sw_ivld_0 = 1'b0;
    sw_bp_0   = 1'b0;
    for (int k = 0; k < 22; k++) begin
      @(negedge ap_clk);
      tests_run++;
      if (sw_ovld_0 !== 1'b1) begin
        tests_failed++;
        $display("FAIL bp_release_stream k=%0d ovld0=%b required 1", k, sw_ovld_0);
      end
      if (k == 0) begin
        tests_run++;
        if (sw_ofw_0 !== 1'b0) begin
          tests_failed++;
          $display("FAIL bp_ofw_drop ofw0=%b required 0", sw_ofw_0);
        end
      end
    end
    wait_drain("bp");
  endtask

  task automatic test_overflow();
    sw_bp_0 = 1'b1;
    for (int k = 0; k < 33; k++) begin
      sw_ivld_0  = 1'b1;
      sw_idata_0 = 32'h0000_0200 + 32'(k);
      if (k < 32) exp_q0.push_back(32'h0000_0200 + 32'(k));
      tick();
      @(negedge ap_clk);
      if (k >= 31) begin
        tests_run++;
        if (err_ovf !== (k == 32)) begin
          tests_failed++;
          $display("FAIL ovf_flag k=%0d err_ovf=%b required %b", k, err_ovf, (k == 32));
        end
      end
    end
    sw_ivld_0 = 1'b0;
    sw_bp_0   = 1'b0;
    for (int k = 0; k < 32; k++) begin
      @(negedge ap_clk);
      tests_run++;
      if (sw_ovld_0 !== 1'b1) begin
        tests_failed++;
        $display("FAIL ovf_stream k=%0d ovld0=%b required 1", k, sw_ovld_0);
      end
    end
    wait_drain("ovf");
    tests_run++;
    if (err_ovf !== 1'b1) begin
      tests_failed++;
      $display("FAIL ovf_sticky err_ovf=%b required 1", err_ovf);
    end
  endtask

  task automatic test_null();
    logic exp_vld;
`ifdef GF_SW_DROP_NULL_EN
    exp_vld = 1'b0;
`else
    exp_vld = 1'b1;
    exp_q0.push_back(32'h003F_FFFF);
`endif
    sw_ivld_0  = 1'b1;
    sw_idata_0 = 32'h003F_FFFF;
    tick();
    sw_ivld_0 = 1'b0;
    tick();
    @(negedge ap_clk);
    tests_run++;
    if (sw_ovld_0 !== exp_vld || sw_ovld_1 !== 1'b0) begin
      tests_failed++;
      $display("FAIL null_route ovld0=%b ovld1=%b required %b 0", sw_ovld_0, sw_ovld_1, exp_vld);
    end
    wait_drain("null");
  endtask

  task automatic test_reset_midstream();
    sw_bp_0 = 1'b1;
    for (int k = 0; k < 24; k++) begin
      sw_ivld_0  = 1'b1;
      sw_idata_0 = 32'h0000_0300 + 32'(k);
      tick();
    end
    sw_ivld_0 = 1'b0;
    @(negedge ap_clk);
    tests_run++;
    if (sw_ofw_0 !== 1'b1) begin
      tests_failed++;
      $display("FAIL rst_pre_ofw ofw0=%b required 1", sw_ofw_0);
    end
    sw_bp_0 = 1'b0;
    exp_q0.push_back(32'h0000_0300);
    tick();
    ap_rst     = 1'b1;
    sw_ivld_0  = 1'b1;
    sw_idata_0 = 32'h0000_0777;
    sw_ivld_1  = 1'b1;
    sw_idata_1 = 32'h0040_0777;
    tick();
    ap_rst    = 1'b0;
    sw_ivld_0 = 1'b0;
    sw_ivld_1 = 1'b0;
    hold0     = '0;
    hold1     = '0;
    exp_q0.delete();
    exp_q1.delete();
    @(negedge ap_clk);
    tests_run++;
    if ({sw_ovld_0, sw_ovld_1, sw_ofw_0, sw_ofw_1, err_ovf} !== 5'b00000) begin
      tests_failed++;
      $display("FAIL rst_mid_flags got=%b required 00000", {sw_ovld_0, sw_ovld_1, sw_ofw_0, sw_ofw_1, err_ovf});
    end
    tests_run++;
    if (sw_odata_0 !== 32'h0 || sw_odata_1 !== 32'h0) begin
      tests_failed++;
      $display("FAIL rst_mid_data got=%h/%h required 0/0", sw_odata_0, sw_odata_1);
    end
    repeat (12) tick();
    tests_run++;
    if (sw_ofw_0 !== 1'b0) begin
      tests_failed++;
      $display("FAIL rst_mid_stale_ofw ofw0=%b required 0", sw_ofw_0);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog_timeout required finish before 200000");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_single();
    test_contention();
    test_rr_alternate();
    test_back_to_back();
    test_backpressure();
    test_overflow();
    test_null();
    test_reset_midstream();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
